// File: rtl/conv_tile_sequencer.sv
// Instruction sequencer for the 8x8 systolic core: one start pulse runs a full conv tile.
// Optional drain watchdog is enabled by defining SEQ_TIMEOUT_EN.
module conv_tile_sequencer #(
    parameter int ROW     = 8,
    parameter int COL     = 8,
    parameter int NPIX    = 16,
    parameter int NKIJ    = 9,
    parameter int ADDR_BW = 11,
    parameter int TMO     = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    ofifo_valid,
    output logic [48:0]             inst,
    output logic                    busy,
    output logic                    done,
    output logic                    out_valid,
    output logic [$clog2(NPIX)-1:0] out_idx,
    output logic                    err_timeout
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WLOAD = 3'd1;
    localparam logic [2:0] S_WPUSH = 3'd2;
    localparam logic [2:0] S_XSTR  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_ACC   = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    localparam int CMAX_A = (ROW + COL > NPIX + 1) ? ROW + COL : NPIX + 1;
    localparam int CMAX   = (CMAX_A > NKIJ + 3) ? CMAX_A : NKIJ + 3;
    localparam int CW     = $clog2(CMAX);
    localparam int KW     = $clog2(NKIJ + 1);
    localparam int OW     = $clog2(NPIX);
    localparam int PW     = $clog2(NPIX + 1);

    localparam logic [CW-1:0] C_WL_LAST  = CW'(ROW);
    localparam logic [CW-1:0] C_WP_LAST  = CW'(ROW + COL - 1);
    localparam logic [CW-1:0] C_XS_LAST  = CW'(NPIX);
    localparam logic [CW-1:0] C_ACC_LAST = CW'(NKIJ + 2);
    localparam logic [CW-1:0] C_ROW      = CW'(ROW);
    localparam logic [CW-1:0] C_NPIX     = CW'(NPIX);
    localparam logic [CW-1:0] C_NKIJ     = CW'(NKIJ);
    localparam logic [CW-1:0] C_NKIJ1    = CW'(NKIJ + 1);
    localparam logic [CW-1:0] C_TWO      = CW'(2);
    localparam logic [KW-1:0] K_LAST     = KW'(NKIJ - 1);
    localparam logic [OW-1:0] O_LAST     = OW'(NPIX - 1);
    localparam logic [PW-1:0] P_NPIX     = PW'(NPIX);
    localparam logic [ADDR_BW-1:0] A_ROW  = ADDR_BW'(ROW);
    localparam logic [ADDR_BW-1:0] A_NPIX = ADDR_BW'(NPIX);

    localparam logic [48:0] IDLE_WORD = (49'd1 << 18) | (49'd1 << 19) | (49'd1 << 31)
                                      | (49'd1 << 32) | (49'd1 << 36) | (49'd1 << 37);

    // The instruction word carries fixed 11-bit address fields; the psum bank must hold every kij.
    if (ADDR_BW != 11 || NKIJ * NPIX > (1 << ADDR_BW) || TMO < 1) begin : g_param_check
        $error("conv_tile_sequencer: illegal parameter set");
    end

    logic [2:0]    state_q, state_n;
    logic [CW-1:0] c_q, c_n;
    logic [KW-1:0] kij_q, kij_n;
    logic [OW-1:0] o_q, o_n;
    logic [PW-1:0] pops_q, pops_n, wrs_q, wrs_n;
    logic          rd_n, wr_n, timeout_hit;

    logic [48:0]         inst_n;
    logic                out_valid_n, done_n;
    logic [OW-1:0]       out_idx_n;
    logic [ADDR_BW-1:0]  c_a, kij_a, o_a, w_a;

    always_comb begin
        state_n = state_q;
        c_n     = c_q + 1'b1;
        kij_n   = kij_q;
        o_n     = o_q;
        pops_n  = pops_q;
        wrs_n   = wrs_q;
        rd_n    = 1'b0;
        wr_n    = 1'b0;
        case (state_q)
            S_IDLE: begin
                c_n = '0;
                if (start) begin
                    state_n = S_WLOAD;
                    kij_n   = '0;
                end
            end
            S_WLOAD: if (c_q == C_WL_LAST) begin
                state_n = S_WPUSH;
                c_n     = '0;
            end
            S_WPUSH: if (c_q == C_WP_LAST) begin
                state_n = S_XSTR;
                c_n     = '0;
            end
            S_XSTR: if (c_q == C_XS_LAST) begin
                // ofifo_valid is registered into ofifo_rd, so the first pop is scheduled here.
                state_n = S_DRAIN;
                c_n     = '0;
                rd_n    = ofifo_valid;
                pops_n  = PW'(ofifo_valid);
                wrs_n   = '0;
            end
            S_DRAIN: begin
                c_n = '0;
                if (wrs_q == P_NPIX) begin
                    if (kij_q == K_LAST) begin
                        state_n = S_ACC;
                        o_n     = '0;
                    end else begin
                        state_n = S_WLOAD;
                        kij_n   = kij_q + 1'b1;
                    end
                end else begin
                    wr_n   = inst[2];
                    wrs_n  = wrs_q + PW'(inst[2]);
                    rd_n   = ofifo_valid && (pops_q != P_NPIX);
                    pops_n = pops_q + PW'(rd_n);
                end
            end
            S_ACC: if (c_q == C_ACC_LAST) begin
                c_n = '0;
                if (o_q == O_LAST) state_n = S_DONE;
                else               o_n     = o_q + 1'b1;
            end
            S_DONE: begin
                state_n = S_IDLE;
                c_n     = '0;
            end
            default: state_n = S_IDLE;
        endcase
        if (abort || timeout_hit) begin
            state_n = S_IDLE;
            c_n     = '0;
            rd_n    = 1'b0;
            wr_n    = 1'b0;
        end
    end

    // Outputs are decoded from the next state so the registered word matches the phase it describes.
    always_comb begin
        inst_n      = IDLE_WORD;
        out_valid_n = 1'b0;
        done_n      = 1'b0;
        out_idx_n   = out_idx;
        c_a         = ADDR_BW'(c_n);
        kij_a       = ADDR_BW'(kij_n);
        o_a         = ADDR_BW'(o_n);
        w_a         = ADDR_BW'(wrs_q);
        case (state_n)
            S_WLOAD: begin
                if (c_n < C_ROW) begin
                    inst_n[36]    = 1'b0;
                    inst_n[48:38] = kij_a * A_ROW + c_a;
                end
                if (c_n != '0) inst_n[3] = 1'b1;
            end
            S_WPUSH: begin
                inst_n[4] = 1'b1;
                inst_n[6] = 1'b1;
            end
            S_XSTR: begin
                if (c_n < C_NPIX) begin
                    inst_n[19]   = 1'b0;
                    inst_n[17:7] = kij_a * A_NPIX + c_a;
                end
                if (c_n != '0) begin
                    inst_n[0] = 1'b1;
                    inst_n[1] = 1'b1;
                    inst_n[5] = 1'b1;
                end
            end
            S_DRAIN: begin
                inst_n[2] = rd_n;
                if (wr_n) begin
                    inst_n[32]    = 1'b0;
                    inst_n[31]    = 1'b0;
                    inst_n[30:20] = kij_a * A_NPIX + w_a;
                end
            end
            S_ACC: begin
                if (c_n == '0) inst_n[34] = 1'b1;
                if (c_n != '0 && c_n <= C_NKIJ) begin
                    inst_n[32]    = 1'b0;
                    inst_n[30:20] = (c_a - 1'b1) * A_NPIX + o_a;
                end
                if (c_n >= C_TWO && c_n <= C_NKIJ1) inst_n[33] = 1'b1;
                if (c_n == C_ACC_LAST) begin
                    out_valid_n = 1'b1;
                    out_idx_n   = o_n;
                end
            end
            S_DONE: done_n = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            c_q       <= '0;
            kij_q     <= '0;
            o_q       <= '0;
            pops_q    <= '0;
            wrs_q     <= '0;
            inst      <= IDLE_WORD;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_idx   <= '0;
        end else begin
            state_q   <= state_n;
            c_q       <= c_n;
            kij_q     <= kij_n;
            o_q       <= o_n;
            pops_q    <= pops_n;
            wrs_q     <= wrs_n;
            inst      <= inst_n;
            busy      <= (state_n != S_IDLE);
            done      <= done_n;
            out_valid <= out_valid_n;
            out_idx   <= out_idx_n;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TMO + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TMO - 1);

    logic [TW-1:0] to_q;
    logic          err_q;

    assign timeout_hit = (state_q == S_DRAIN) && (to_q == T_LAST);

    // Counter restarts on every pop and is zero outside DRAIN, so entry counts as a fresh start.
    always_ff @(posedge clk) begin
        if (reset) begin
            to_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q != S_DRAIN || inst[2] || timeout_hit) to_q <= '0;
            else                                              to_q <= to_q + 1'b1;
            if (state_q == S_IDLE && start && !abort) err_q <= 1'b0;
            else if (timeout_hit && !abort)           err_q <= 1'b1;
        end
    end

    assign err_timeout = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_conv_tile_sequencer.sv
// Directed bench for conv_tile_sequencer with a psum-write / out_idx scoreboard.
module tb_conv_tile_sequencer;

    localparam int ROW     = 8;
    localparam int COL     = 8;
    localparam int NPIX    = 16;
    localparam int NKIJ    = 9;
    localparam int ADDR_BW = 11;
    localparam int TMO     = 20;
    localparam int OW      = $clog2(NPIX);
    localparam int PER     = 2*ROW + COL + NPIX + 2 + NPIX + 1;
    localparam int ACC_LEN = NPIX * (NKIJ + 3);
    localparam int DRAIN0  = 1 + (ROW + 1) + (ROW + COL) + (NPIX + 1);
    localparam logic [48:0] IDLE_WORD = 49'h31_800C_0000;

    logic clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0, ofifo_valid = 1'b0;
    logic [48:0]   inst;
    logic          busy, done, out_valid, err_timeout;
    logic [OW-1:0] out_idx;

    int checks = 0, failures = 0, k = 0, pops = 0, dones = 0;
    logic prev_rd = 1'b0;
    logic [10:0]   wr_q[$];
    logic [OW-1:0] out_q[$];

    conv_tile_sequencer #(
        .ROW(ROW), .COL(COL), .NPIX(NPIX), .NKIJ(NKIJ), .ADDR_BW(ADDR_BW), .TMO(TMO)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .ofifo_valid(ofifo_valid),
        .inst(inst), .busy(busy), .done(done), .out_valid(out_valid), .out_idx(out_idx),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (inst[32] === 1'b0 && inst[31] === 1'b0) begin
                chk("wr_after_pop", prev_rd, 1'b1);
                chk("wr_expected", wr_q.size() != 0, 1'b1);
                if (wr_q.size() != 0) chk("psum_wr_addr", inst[30:20], wr_q.pop_front());
            end
            if (out_valid === 1'b1) begin
                chk("out_expected", out_q.size() != 0, 1'b1);
                if (out_q.size() != 0) chk("out_idx", out_idx, out_q.pop_front());
            end
            if (inst[2] === 1'b1) pops++;
            if (done === 1'b1) dones++;
        end
        prev_rd <= inst[2];
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 1;
    endtask

    task automatic adv_to(input int t);
        for (int i = k; i < t; i++) @(negedge clk);
        k = t;
    endtask

    task automatic run_tile(input bit toggle);
        bit seen;
        int c;
        pops  = 0;
        dones = 0;
        for (int a = 0; a < NKIJ*NPIX; a++) wr_q.push_back(11'(a));
        for (int o = 0; o < NPIX; o++) out_q.push_back(OW'(o));
        ofifo_valid = 1'b1;
        pulse_start();
        seen = 1'b0;
        while (!seen && k <= 4000) begin
            if (k == 1) begin
                chk("wl0_busy", busy, 1'b1);
                chk("wl0_cen", inst[36], 1'b0);
                chk("wl0_addr", inst[48:38], 0);
                chk("wl0_ififo_wr", inst[3], 1'b0);
            end
            if (!toggle && k >= 1 + 2*PER && k <= 1 + 2*PER + ROW) begin
                c = k - (1 + 2*PER);
                chk("kij2_w_cen", inst[36], (c < ROW) ? 1'b0 : 1'b1);
                if (c < ROW) chk("kij2_w_addr", inst[48:38], 2*ROW + c);
                chk("kij2_ififo_wr", inst[3], (c >= 1) ? 1'b1 : 1'b0);
            end
            if (!toggle && k == 1 + NKIJ*PER) chk("acc_sfp_clr", inst[34], 1'b1);
            if (!toggle && k == 2 + NKIJ*PER) begin
                chk("acc_rd_cen", inst[32], 1'b0);
                chk("acc_rd_addr", inst[30:20], 0);
                chk("acc_strobe_c1", inst[33], 1'b0);
            end
            if (!toggle && k == 3 + NKIJ*PER) begin
                chk("acc_rd_addr_c2", inst[30:20], NPIX);
                chk("acc_strobe_c2", inst[33], 1'b1);
            end
            if (done === 1'b1) begin
                seen = 1'b1;
                if (!toggle) chk("done_latency", k, 1 + NKIJ*PER + ACC_LEN);
            end else begin
                if (toggle) ofifo_valid = ~ofifo_valid;
                @(negedge clk);
                k++;
            end
        end
        chk("done_seen", seen, 1'b1);
        @(negedge clk);
        chk("done_one_cycle", done, 1'b0);
        chk("post_busy", busy, 1'b0);
        chk("post_inst", inst, IDLE_WORD);
        chk("wr_q_drained", wr_q.size(), 0);
        chk("out_q_drained", out_q.size(), 0);
        chk("pop_count", pops, NKIJ*NPIX);
        chk("done_count", dones, 1);
        ofifo_valid = 1'b0;
        wr_q.delete();
        out_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_inst", inst, IDLE_WORD);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_err", err_timeout, 1'b0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        run_tile(1'b0);
        repeat (2) @(negedge clk);
        run_tile(1'b1);
        repeat (2) @(negedge clk);

        // start while busy, then abort mid X_STREAM of kij=4
        dones = 0;
        for (int a = 0; a < 4*NPIX; a++) wr_q.push_back(11'(a));
        ofifo_valid = 1'b1;
        pulse_start();
        adv_to(4);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 5;
        chk("busy_start_addr", inst[48:38], 4);
        chk("busy_start_cen", inst[36], 1'b0);
        adv_to(1 + 4*PER + (ROW + 1) + (ROW + COL) + 5);
        chk("kij4_x_cen", inst[19], 1'b0);
        chk("kij4_x_addr", inst[17:7], 4*NPIX + 5);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_inst", inst, IDLE_WORD);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        repeat (5) @(negedge clk);
        chk("abort_stays_idle", busy, 1'b0);
        chk("abort_wr_q", wr_q.size(), 0);
        chk("abort_no_done", dones, 0);

        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        chk("abort_start_busy", busy, 1'b0);
        chk("abort_start_inst", inst, IDLE_WORD);
        repeat (2) @(negedge clk);

        // drain with ofifo_valid held low
        ofifo_valid = 1'b0;
        dones = 0;
        pops  = 0;
        pulse_start();
        adv_to(DRAIN0);
        chk("drain_entry_busy", busy, 1'b1);
        chk("drain_entry_no_pop", inst[2], 1'b0);
`ifdef SEQ_TIMEOUT_EN
        adv_to(DRAIN0 + TMO - 1);
        chk("tmo_pre_busy", busy, 1'b1);
        chk("tmo_pre_err", err_timeout, 1'b0);
        adv_to(DRAIN0 + TMO);
        chk("tmo_err", err_timeout, 1'b1);
        chk("tmo_busy", busy, 1'b0);
        chk("tmo_inst", inst, IDLE_WORD);
        chk("tmo_done", done, 1'b0);
        @(negedge clk);
        chk("tmo_err_sticky", err_timeout, 1'b1);
        pulse_start();
        chk("tmo_err_cleared", err_timeout, 1'b0);
        chk("tmo_restart_busy", busy, 1'b1);
`else
        adv_to(DRAIN0 + 300);
        chk("wait_busy", busy, 1'b1);
        chk("wait_err", err_timeout, 1'b0);
        chk("wait_no_pop", pops, 0);
`endif
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("final_busy", busy, 1'b0);
        chk("final_no_done", dones, 0);
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
